// File: rtl/vector_reg_file_masked_pkg.sv
// Shared shader register-file definitions: register map indices and FSM states.
package vector_reg_file_masked_pkg;

    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_READY = 1'b1
    } vrf_state_e;

    // Register map indices, all derived from the architectural register count.
    function automatic int unsigned REG_ZERO(input int unsigned reg_count);
        return (reg_count > 0) ? 0 : 0;
    endfunction

    function automatic int unsigned REG_BTN(input int unsigned reg_count);
        return reg_count - 4;
    endfunction

    function automatic int unsigned REG_LANE(input int unsigned reg_count);
        return reg_count - 3;
    endfunction

    function automatic int unsigned REG_Y(input int unsigned reg_count);
        return reg_count - 2;
    endfunction

    function automatic int unsigned REG_TIME(input int unsigned reg_count);
        return reg_count - 1;
    endfunction

    function automatic int unsigned REG_GP_LAST(input int unsigned reg_count);
        return reg_count - 5;
    endfunction

endpackage

// File: rtl/vector_reg_file_masked_read_port.sv
// One registered read port: address decode, special-register mux and
// write-to-read bypass merge.
module vrf_read_port
    import vector_reg_file_masked_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned REG_COUNT  = 16,
    parameter int unsigned AW         = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AW-1:0]               r_addr,
    input  logic [LANES*DATA_WIDTH-1:0] mem_data,
    input  logic                        wr_commit,
    input  logic [AW-1:0]               w_addr,
    input  logic [LANES-1:0]            w_mask,
    input  logic [LANES*DATA_WIDTH-1:0] w_data,
    input  logic [3:0]                  buttons,
    input  logic [DATA_WIDTH-1:0]       i_time,
    input  logic [DATA_WIDTH-1:0]       i_y,
    output logic [LANES*DATA_WIDTH-1:0] r_data
);

    localparam logic [AW-1:0] A_ZERO = AW'(REG_ZERO(REG_COUNT));
    localparam logic [AW-1:0] A_BTN  = AW'(REG_BTN(REG_COUNT));
    localparam logic [AW-1:0] A_LANE = AW'(REG_LANE(REG_COUNT));
    localparam logic [AW-1:0] A_Y    = AW'(REG_Y(REG_COUNT));
    localparam logic [AW-1:0] A_TIME = AW'(REG_TIME(REG_COUNT));

    logic [LANES*DATA_WIDTH-1:0] rd_next;
    logic                        hit;

    // Select the value to capture: special source, zero, or stored row merged with a same-edge write.
    always_comb begin
        rd_next = '0;
        hit     = wr_commit && (w_addr == r_addr);
        case (r_addr)
            A_ZERO: rd_next = '0;
            A_BTN: begin
                for (int unsigned k = 0; k < LANES; k++)
                    rd_next[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(buttons);
            end
            A_LANE: begin
                for (int unsigned k = 0; k < LANES; k++)
                    rd_next[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(k);
            end
            A_Y: begin
                for (int unsigned k = 0; k < LANES; k++)
                    rd_next[k*DATA_WIDTH +: DATA_WIDTH] = i_y;
            end
            A_TIME: begin
                for (int unsigned k = 0; k < LANES; k++)
                    rd_next[k*DATA_WIDTH +: DATA_WIDTH] = i_time;
            end
            default: begin
                for (int unsigned k = 0; k < LANES; k++)
                    rd_next[k*DATA_WIDTH +: DATA_WIDTH] = (hit && w_mask[k])
                        ? w_data[k*DATA_WIDTH +: DATA_WIDTH]
                        : mem_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        endcase
    end

    // Register the read result; reset forces zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_data <= '0;
        else
            r_data <= rd_next;
    end

endmodule

// File: rtl/vector_reg_file_masked.sv
// 2-read/1-write vector register file with per-lane write mask, registered
// bypassing reads, special registers and a one-row-per-cycle scrub engine.
module vector_reg_file_masked
    import vector_reg_file_masked_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned REG_COUNT  = 16,
    localparam int unsigned AW        = $clog2(REG_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic [AW-1:0]               w_addr,
    input  logic [LANES-1:0]            w_mask,
    input  logic [LANES*DATA_WIDTH-1:0] w_data,
    input  logic [AW-1:0]               r_addr1,
    input  logic [AW-1:0]               r_addr2,
    input  logic                        i_clear,
    input  logic [3:0]                  buttons,
    input  logic [DATA_WIDTH-1:0]       i_time,
    input  logic [DATA_WIDTH-1:0]       i_y,
    output logic [LANES*DATA_WIDTH-1:0] r_data1,
    output logic [LANES*DATA_WIDTH-1:0] r_data2,
    output logic                        o_ready,
    output logic                        o_wr_err
);

    localparam logic [AW-1:0] GP_FIRST = AW'(1);
    localparam logic [AW-1:0] GP_LAST  = AW'(REG_GP_LAST(REG_COUNT));

    vrf_state_e                  state;
    logic [AW-1:0]               scrub_ptr;
    logic                        addr_general;
    logic                        commit;
    logic                        scrub_en;
    logic [LANES*DATA_WIDTH-1:0] mem [REG_COUNT];

    // Decide whether this cycle's write lands and whether the scrub engine owns the array.
    always_comb begin
        addr_general = (w_addr >= GP_FIRST) && (w_addr <= GP_LAST);
        commit       = rst_n && we && (state == ST_READY) && addr_general;
        scrub_en     = rst_n && (state == ST_SCRUB);
    end

    // Storage array: no reset, single write path shared by scrub and masked commits.
    always_ff @(posedge clk) begin
        if (scrub_en) begin
            mem[scrub_ptr] <= '0;
        end else if (commit) begin
            for (int unsigned k = 0; k < LANES; k++)
                if (w_mask[k])
                    mem[w_addr][k*DATA_WIDTH +: DATA_WIDTH] <= w_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scrub/ready state machine with registered ready and write-error outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_SCRUB;
            scrub_ptr <= GP_FIRST;
            o_ready   <= 1'b0;
            o_wr_err  <= 1'b0;
        end else begin
            o_wr_err <= we && !commit;
            case (state)
                ST_SCRUB: begin
                    if (scrub_ptr == GP_LAST) begin
                        state   <= ST_READY;
                        o_ready <= 1'b1;
                    end else begin
                        scrub_ptr <= scrub_ptr + AW'(1);
                    end
                end
                ST_READY: begin
                    if (i_clear) begin
                        state     <= ST_SCRUB;
                        scrub_ptr <= GP_FIRST;
                        o_ready   <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_SCRUB;
                    scrub_ptr <= GP_FIRST;
                    o_ready   <= 1'b0;
                end
            endcase
        end
    end

    vrf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .REG_COUNT  (REG_COUNT),
        .AW         (AW)
    ) u_port1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_addr    (r_addr1),
        .mem_data  (mem[r_addr1]),
        .wr_commit (commit),
        .w_addr    (w_addr),
        .w_mask    (w_mask),
        .w_data    (w_data),
        .buttons   (buttons),
        .i_time    (i_time),
        .i_y       (i_y),
        .r_data    (r_data1)
    );

    vrf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .REG_COUNT  (REG_COUNT),
        .AW         (AW)
    ) u_port2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_addr    (r_addr2),
        .mem_data  (mem[r_addr2]),
        .wr_commit (commit),
        .w_addr    (w_addr),
        .w_mask    (w_mask),
        .w_data    (w_data),
        .buttons   (buttons),
        .i_time    (i_time),
        .i_y       (i_y),
        .r_data    (r_data2)
    );

endmodule

// File: tb/tb_vector_reg_file_masked.sv
// Self-checking bench for vector_reg_file_masked: directed scenarios plus a
// randomized run against a lane-level reference model.
module tb_vector_reg_file_masked;

    localparam int R = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-configuration DUT signals
    logic        rst_n, we, i_clear;
    logic [3:0]  w_addr, r_addr1, r_addr2, w_mask, buttons;
    logic [31:0] w_data, r_data1, r_data2;
    logic [7:0]  i_time, i_y;
    logic        o_ready, o_wr_err;

    // Wide-configuration DUT signals
    logic         rst2_n, we2, i_clear2;
    logic [4:0]   w_addr2, r2_addr1, r2_addr2;
    logic [7:0]   w_mask2;
    logic [127:0] w_data2, r2_data1, r2_data2;
    logic [3:0]   buttons2;
    logic [15:0]  i_time2, i_y2;
    logic         o_ready2, o_wr_err2;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [R];

    vector_reg_file_masked dut (
        .clk(clk), .rst_n(rst_n), .we(we), .w_addr(w_addr), .w_mask(w_mask),
        .w_data(w_data), .r_addr1(r_addr1), .r_addr2(r_addr2), .i_clear(i_clear),
        .buttons(buttons), .i_time(i_time), .i_y(i_y), .r_data1(r_data1),
        .r_data2(r_data2), .o_ready(o_ready), .o_wr_err(o_wr_err)
    );

    vector_reg_file_masked #(.DATA_WIDTH(16), .LANES(8), .REG_COUNT(32)) dut2 (
        .clk(clk), .rst_n(rst2_n), .we(we2), .w_addr(w_addr2), .w_mask(w_mask2),
        .w_data(w_data2), .r_addr1(r2_addr1), .r_addr2(r2_addr2), .i_clear(i_clear2),
        .buttons(buttons2), .i_time(i_time2), .i_y(i_y2), .r_data1(r2_data1),
        .r_data2(r2_data2), .o_ready(o_ready2), .o_wr_err(o_wr_err2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] m, input logic [31:0] d);
        we = 1'b1; w_addr = a; w_mask = m; w_data = d;
        step();
        we = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a1, input logic [3:0] a2);
        we = 1'b0; r_addr1 = a1; r_addr2 = a2;
        step();
    endtask

    task automatic wait_ready(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (o_ready === 1'b1) begin
                cyc = c;
                return;
            end
        end
    endtask

    // Expected read value for the current inputs, derived from the register map rules.
    function automatic logic [31:0] model_read(input logic [3:0] a, input logic wr_ok);
        logic [31:0] v;
        if (a == 0)            v = '0;
        else if (a == R - 4)   v = {4{4'b0000, buttons}};
        else if (a == R - 3)   v = 32'h03020100;
        else if (a == R - 2)   v = {4{i_y}};
        else if (a == R - 1)   v = {4{i_time}};
        else begin
            v = model[a];
            if (wr_ok && w_addr == a)
                for (int k = 0; k < 4; k++)
                    if (w_mask[k]) v[8*k +: 8] = w_data[8*k +: 8];
        end
        return v;
    endfunction

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0; we = 1'b1; w_addr = 4'd3; w_mask = 4'hF; w_data = 32'hFFFF_FFFF;
        step();
        step();
        checks++; if (r_data1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected 0", r_data1); end
        checks++; if (r_data2 !== 32'h0) begin errors++; $display("FAIL reset_rdata2: got %h expected 0", r_data2); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", o_ready); end
        checks++; if (o_wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", o_wr_err); end
        we = 1'b0; rst_n = 1'b1;
        wait_ready(cyc);
        checks++; if (cyc != 11) begin errors++; $display("FAIL reset_scrub_len: got %0d expected 11", cyc); end
        for (int a = 1; a <= 11; a += 2) begin
            do_read(4'(a), 4'(a + 1));
            checks++; if (r_data1 !== 32'h0) begin errors++; $display("FAIL scrubbed_v%0d: got %h expected 0", a, r_data1); end
            checks++; if (r_data2 !== 32'h0) begin errors++; $display("FAIL scrubbed_v%0d: got %h expected 0", a + 1, r_data2); end
        end
    endtask

    task automatic test_masked_write();
        do_write(4'd3, 4'hF, 32'hAABBCCDD);
        do_write(4'd3, 4'h5, 32'h11223344);
        checks++; if (o_wr_err !== 1'b0) begin errors++; $display("FAIL masked_no_err: got %b expected 0", o_wr_err); end
        do_write(4'd3, 4'h0, 32'h55555555);
        checks++; if (o_wr_err !== 1'b0) begin errors++; $display("FAIL zero_mask_no_err: got %b expected 0", o_wr_err); end
        do_read(4'd3, 4'd3);
        checks++; if (r_data1 !== 32'hAA22CC44) begin errors++; $display("FAIL masked_write: got %h expected aa22cc44", r_data1); end
    endtask

    task automatic test_bypass();
        r_addr1 = 4'd5; r_addr2 = 4'd5;
        do_write(4'd5, 4'hF, 32'h01020304);
        checks++; if (r_data1 !== 32'h01020304) begin errors++; $display("FAIL bypass_p1: got %h expected 01020304", r_data1); end
        checks++; if (r_data2 !== 32'h01020304) begin errors++; $display("FAIL bypass_p2: got %h expected 01020304", r_data2); end
        r_addr1 = 4'd5; r_addr2 = 4'd3;
        do_write(4'd5, 4'h6, 32'hA0B0C0D0);
        checks++; if (r_data1 !== 32'h01B0C004) begin errors++; $display("FAIL bypass_partial: got %h expected 01b0c004", r_data1); end
        checks++; if (r_data2 !== 32'hAA22CC44) begin errors++; $display("FAIL bypass_other: got %h expected aa22cc44", r_data2); end
    endtask

    task automatic test_special();
        buttons = 4'b1010; i_y = 8'h37; i_time = 8'h9C;
        do_read(4'd12, 4'd13);
        checks++; if (r_data1 !== 32'h0A0A0A0A) begin errors++; $display("FAIL spec_btn: got %h expected 0a0a0a0a", r_data1); end
        checks++; if (r_data2 !== 32'h03020100) begin errors++; $display("FAIL spec_lane: got %h expected 03020100", r_data2); end
        do_read(4'd14, 4'd15);
        checks++; if (r_data1 !== 32'h37373737) begin errors++; $display("FAIL spec_y: got %h expected 37373737", r_data1); end
        checks++; if (r_data2 !== 32'h9C9C9C9C) begin errors++; $display("FAIL spec_time: got %h expected 9c9c9c9c", r_data2); end
    endtask

    task automatic test_illegal();
        int cyc;
        do_write(4'd0, 4'hF, 32'hDEADBEEF);
        checks++; if (o_wr_err !== 1'b1) begin errors++; $display("FAIL err_v0: got %b expected 1", o_wr_err); end
        do_read(4'd0, 4'd14);
        checks++; if (o_wr_err !== 1'b0) begin errors++; $display("FAIL err_v0_pulse: got %b expected 0", o_wr_err); end
        checks++; if (r_data1 !== 32'h0) begin errors++; $display("FAIL v0_unchanged: got %h expected 0", r_data1); end
        do_write(4'd14, 4'hF, 32'hDEADBEEF);
        checks++; if (o_wr_err !== 1'b1) begin errors++; $display("FAIL err_v14: got %b expected 1", o_wr_err); end
        do_read(4'd14, 4'd3);
        checks++; if (o_wr_err !== 1'b0) begin errors++; $display("FAIL err_v14_pulse: got %b expected 0", o_wr_err); end
        checks++; if (r_data1 !== 32'h37373737) begin errors++; $display("FAIL v14_unchanged: got %h expected 37373737", r_data1); end
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        do_write(4'd2, 4'hF, 32'h12345678);
        checks++; if (o_wr_err !== 1'b1) begin errors++; $display("FAIL err_scrub: got %b expected 1", o_wr_err); end
        wait_ready(cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL illegal_ready_timeout: got %0d expected >0", cyc); end
        do_read(4'd2, 4'd3);
        checks++; if (r_data1 !== 32'h0) begin errors++; $display("FAIL scrub_write_dropped: got %h expected 0", r_data1); end
    endtask

    task automatic test_clear();
        int cyc;
        logic bad;
        for (int a = 1; a <= 11; a++) do_write(4'(a), 4'hF, $urandom | 32'h1);
        w_addr = 4'd4; w_mask = 4'hF; w_data = 32'hCAFEF00D; we = 1'b1; i_clear = 1'b1;
        step();
        we = 1'b0; i_clear = 1'b0;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL clear_ready_drop: got %b expected 0", o_ready); end
        wait_ready(cyc);
        checks++; if (cyc != 11) begin errors++; $display("FAIL clear_scrub_len: got %0d expected 11", cyc); end
        bad = 1'b0;
        for (int a = 0; a < 12; a++) begin
            do_read(4'(a), 4'(a));
            if (r_data1 !== 32'h0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL clear_all_zero: got %b expected 0", bad); end

        for (int a = 1; a <= 11; a++) do_write(4'(a), 4'hF, $urandom | 32'h1);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        for (int c = 0; c < 5; c++) step();
        rst_n = 1'b0;
        step();
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL midscrub_reset_ready: got %b expected 0", o_ready); end
        rst_n = 1'b1;
        wait_ready(cyc);
        checks++; if (cyc != 11) begin errors++; $display("FAIL midscrub_scrub_len: got %0d expected 11", cyc); end
        bad = 1'b0;
        for (int a = 1; a < 12; a++) begin
            do_read(4'(a), 4'(a));
            if (r_data2 !== 32'h0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL midscrub_all_zero: got %b expected 0", bad); end
    endtask

    task automatic test_random();
        logic [31:0] exp1, exp2;
        logic        legal;
        for (int a = 0; a < R; a++) model[a] = '0;
        for (int n = 0; n < 400; n++) begin
            we      = 1'($urandom_range(0, 1));
            w_addr  = 4'($urandom);
            w_mask  = 4'($urandom);
            w_data  = $urandom;
            r_addr1 = ($urandom_range(0, 3) == 0) ? w_addr : 4'($urandom);
            r_addr2 = 4'($urandom);
            buttons = 4'($urandom);
            i_time  = 8'($urandom);
            i_y     = 8'($urandom);
            legal   = we && (w_addr >= 1) && (w_addr <= R - 5);
            exp1    = model_read(r_addr1, legal);
            exp2    = model_read(r_addr2, legal);
            step();
            checks++; if (r_data1 !== exp1) begin errors++; $display("FAIL rand_p1[%0d] addr %0d: got %h expected %h", n, r_addr1, r_data1, exp1); end
            checks++; if (r_data2 !== exp2) begin errors++; $display("FAIL rand_p2[%0d] addr %0d: got %h expected %h", n, r_addr2, r_data2, exp2); end
            checks++; if (o_wr_err !== (we && !legal)) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", n, o_wr_err, we && !legal); end
            if (legal)
                for (int k = 0; k < 4; k++)
                    if (w_mask[k]) model[w_addr][8*k +: 8] = w_data[8*k +: 8];
        end
        we = 1'b0;
    endtask

    task automatic test_wide();
        int cyc;
        rst2_n = 1'b0;
        step();
        checks++; if (r2_data1 !== 128'h0) begin errors++; $display("FAIL wide_reset_rdata: got %h expected 0", r2_data1); end
        rst2_n = 1'b1;
        cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (o_ready2 === 1'b1) begin
                cyc = c;
                break;
            end
        end
        checks++; if (cyc != 27) begin errors++; $display("FAIL wide_scrub_len: got %0d expected 27", cyc); end
        r2_addr1 = 5'd29; r2_addr2 = 5'd0;
        step();
        checks++; if (r2_data1 !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin
            errors++; $display("FAIL wide_lane_reg: got %h expected 00070006000500040003000200010000", r2_data1);
        end
        checks++; if (r2_data2 !== 128'h0) begin errors++; $display("FAIL wide_v0: got %h expected 0", r2_data2); end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; i_clear = 1'b0; w_addr = '0; w_mask = '0; w_data = '0;
        r_addr1 = '0; r_addr2 = '0; buttons = '0; i_time = '0; i_y = '0;
        rst2_n = 1'b0; we2 = 1'b0; i_clear2 = 1'b0; w_addr2 = '0; w_mask2 = '0; w_data2 = '0;
        r2_addr1 = '0; r2_addr2 = '0; buttons2 = 4'h5; i_time2 = 16'h1234; i_y2 = 16'h00AB;

        test_reset();
        test_masked_write();
        test_bypass();
        test_special();
        test_illegal();
        test_clear();
        test_random();
        test_wide();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
